seq_region_cfg_ctrl: RTL and testbench

SEQ_REGION_CFG_CTRL -- requirements
Module: seq_region_cfg_ctrl

---
 rtl/seq_region_cfg_ctrl_pkg.sv | 18 +
 rtl/seq_region_cfg_ctrl_if.sv | 41 ++++
 rtl/seq_region_cfg_ctrl_outstanding_counter.sv | 37 +++
 rtl/seq_region_cfg_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_region_cfg_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_region_cfg_ctrl_pkg.sv
// Shared types and width helpers for the sequential-region config controller.
package seq_cfg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_UPDATE = 2'd2
  } cfg_state_e;

  function automatic int seq_bits_width(input int max_seq_bits);
    return $clog2(max_seq_bits + 1);
  endfunction

  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/seq_region_cfg_ctrl_if.sv
// Config, request-gate and response signals of the region config controller.
interface seq_region_cfg_ctrl_if #(
  parameter int MaxSeqBits = 16
) ();
  import seq_cfg_pkg::*;

  localparam int SeqBitsWidth = seq_bits_width(MaxSeqBits);

  logic                    cfg_valid_i;
  logic [SeqBitsWidth-1:0] cfg_seq_bits_i;
  logic                    cfg_bypass_i;
  logic                    cfg_ready_o;
  logic                    cfg_err_o;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_valid_o;
  logic                    req_ready_i;
  logic                    rsp_valid_i;
  logic [SeqBitsWidth-1:0] seq_bits_o;
  logic                    bypass_o;
  logic                    busy_o;

  modport slave (
    input  cfg_valid_i, cfg_seq_bits_i, cfg_bypass_i,
    output cfg_ready_o, cfg_err_o,
    input  req_valid_i, output req_ready_o,
    output req_valid_o, input  req_ready_i,
    input  rsp_valid_i,
    output seq_bits_o, bypass_o, busy_o
  );

  modport master (
    output cfg_valid_i, cfg_seq_bits_i, cfg_bypass_i,
    input  cfg_ready_o, cfg_err_o,
    output req_valid_i, input  req_ready_o,
    input  req_valid_o, output req_ready_i,
    output rsp_valid_i,
    input  seq_bits_o, bypass_o, busy_o
  );

endinterface

// File: rtl/seq_region_cfg_ctrl_outstanding_counter.sv
// Saturating in-flight request counter; a response at zero is ignored.
module outstanding_counter #(
  parameter int MaxCount = 8,
  parameter int CntW     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dec_eff;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(MaxCount));
  assign count_o = cnt_q;
  assign dec_eff = dec_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_eff})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_region_cfg_ctrl.sv
// Drains in-flight requests before switching the scrambled region's per-tile
// sequential size / bypass mode, so no request sees a mixed mapping.
module seq_region_cfg_ctrl
  import seq_cfg_pkg::*;
#(
  parameter int NumTiles        = 4,
  parameter int ByteOffset      = 2,
  parameter int NumBanksPerTile = 16,
  parameter int MaxSeqBits      = 16,
  parameter int DefaultSeqBits  = 12,
  parameter int MaxOutstanding  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  seq_region_cfg_ctrl_if.slave bus
);

  localparam int SeqBitsWidth = seq_bits_width(MaxSeqBits);
  localparam int CntWidth     = cnt_width(MaxOutstanding);
  localparam int MinSeqBits   = ByteOffset + $clog2(NumBanksPerTile);

  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [1:0] S_UPDATE = ST_UPDATE;

  if (DefaultSeqBits < MinSeqBits || DefaultSeqBits > MaxSeqBits) begin : g_bad_default
    $fatal(1, "DefaultSeqBits outside legal range");
  end
  if (NumTiles < 2) begin : g_bad_tiles
    $fatal(1, "NumTiles must be at least 2");
  end
  if (MaxOutstanding < 1) begin : g_bad_outstanding
    $fatal(1, "MaxOutstanding must be at least 1");
  end

  function automatic logic cfg_legal(input logic [SeqBitsWidth-1:0] bits, input logic byp);
    return byp || ((int'(bits) >= MinSeqBits) && (int'(bits) <= MaxSeqBits));
  endfunction

  logic [1:0]              state_q, state_d;
  logic [SeqBitsWidth-1:0] seq_bits_q, pend_bits_q;
  logic                    bypass_q, pend_bypass_q;
  logic                    accept, cfg_ready, cfg_err;
  logic                    gate_open, cnt_inc, cnt_full, cnt_empty;
  logic [CntWidth-1:0]     cnt;

  assign gate_open       = (state_q == S_RUN) && !cnt_full;
  assign bus.req_valid_o = gate_open & bus.req_valid_i;
  assign bus.req_ready_o = gate_open & bus.req_ready_i;
  assign cnt_inc         = bus.req_valid_o & bus.req_ready_i;

  outstanding_counter #(
    .MaxCount (MaxOutstanding),
    .CntW     (CntWidth)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (cnt_inc),
    .dec_i   (bus.rsp_valid_i),
    .full_o  (cnt_full),
    .empty_o (cnt_empty),
    .count_o (cnt)
  );

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    cfg_err   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.cfg_valid_i) begin
          if (cfg_legal(bus.cfg_seq_bits_i, bus.cfg_bypass_i)) begin
            accept  = 1'b1;
            state_d = S_DRAIN;
          end else begin
            cfg_ready = 1'b1;
            cfg_err   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The last outstanding response may retire in this very cycle.
        if (cnt_empty || (cnt == CntWidth'(1) && bus.rsp_valid_i)) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        cfg_ready = 1'b1;
        state_d   = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // A reset in the same cycle aborts the handshake entirely.
  assign bus.cfg_ready_o = cfg_ready & ~rst_i;
  assign bus.cfg_err_o   = cfg_err & ~rst_i;
  assign bus.busy_o      = (state_q != S_RUN);
  assign bus.seq_bits_o  = seq_bits_q;
  assign bus.bypass_o    = bypass_q;

  // Captured at acceptance so a requester dropping cfg_valid mid-drain is harmless.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pend_bits_q   <= bus.cfg_seq_bits_i;
      pend_bypass_q <= bus.cfg_bypass_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      seq_bits_q <= SeqBitsWidth'(DefaultSeqBits);
      bypass_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_UPDATE) begin
        seq_bits_q <= pend_bits_q;
        bypass_q   <= pend_bypass_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_region_cfg_ctrl.sv
// Directed bench for seq_region_cfg_ctrl at default parameters.
module tb_seq_region_cfg_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_region_cfg_ctrl_if #(.MaxSeqBits(16)) bus ();

  seq_region_cfg_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_ready_i = 1'b1;
      cyc();
    end
    bus.req_valid_i = 1'b0;
    bus.req_ready_i = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rsp_valid_i = 1'b1;
      cyc();
    end
    bus.rsp_valid_i = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.cfg_valid_i    = 1'b0;
    bus.cfg_seq_bits_i = '0;
    bus.cfg_bypass_i   = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_ready_i    = 1'b0;
    bus.rsp_valid_i    = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_seq_bits", bus.seq_bits_o, 12);
    chk("rst_bypass", bus.bypass_o, 0);
    chk("rst_cfg_ready", bus.cfg_ready_o, 0);
    chk("rst_cfg_err", bus.cfg_err_o, 0);
    bus.req_valid_i = 1'b1;
    #1;
    chk("run_gate_valid", bus.req_valid_o, 1);
    chk("run_gate_ready", bus.req_ready_o, 0);
    bus.req_valid_i = 1'b0;

    // Illegal configs: below minimum and above MaxSeqBits.
    cyc();
    bus.cfg_valid_i = 1'b1;
    bus.cfg_seq_bits_i = 5'd3;
    #1;
    chk("illegal3_ready", bus.cfg_ready_o, 1);
    chk("illegal3_err", bus.cfg_err_o, 1);
    chk("illegal3_busy", bus.busy_o, 0);
    cyc();
    bus.cfg_seq_bits_i = 5'd17;
    #1;
    chk("illegal17_err", bus.cfg_err_o, 1);
    bus.cfg_valid_i = 1'b0;
    cyc();
    chk("illegal_seq_kept", bus.seq_bits_o, 12);
    chk("illegal_busy_kept", bus.busy_o, 0);
    chk("illegal_ready_idle", bus.cfg_ready_o, 0);

    // Minimum-latency update to 13 with nothing outstanding.
    bus.cfg_valid_i = 1'b1;
    bus.cfg_seq_bits_i = 5'd13;
    #1;
    chk("upd13_c0_ready", bus.cfg_ready_o, 0);
    chk("upd13_c0_err", bus.cfg_err_o, 0);
    chk("upd13_c0_busy", bus.busy_o, 0);
    cyc();
    chk("upd13_c1_busy", bus.busy_o, 1);
    chk("upd13_c1_ready", bus.cfg_ready_o, 0);
    cyc();
    chk("upd13_c2_busy", bus.busy_o, 1);
    chk("upd13_c2_ready", bus.cfg_ready_o, 1);
    chk("upd13_c2_err", bus.cfg_err_o, 0);
    chk("upd13_c2_seq_old", bus.seq_bits_o, 12);
    bus.cfg_valid_i = 1'b0;
    cyc();
    chk("upd13_c3_seq", bus.seq_bits_o, 13);
    chk("upd13_c3_busy", bus.busy_o, 0);
    bus.req_valid_i = 1'b1;
    #1;
    chk("upd13_c3_gate", bus.req_valid_o, 1);
    bus.req_valid_i = 1'b0;

    // Update to 14 with three requests in flight.
    fill(3);
    bus.cfg_valid_i = 1'b1;
    bus.cfg_seq_bits_i = 5'd14;
    cyc();
    bus.req_valid_i = 1'b1;
    bus.req_ready_i = 1'b1;
    #1;
    chk("drain_valid_closed", bus.req_valid_o, 0);
    chk("drain_ready_closed", bus.req_ready_o, 0);
    chk("drain_busy", bus.busy_o, 1);
    bus.rsp_valid_i = 1'b1;
    cyc();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("drain_d2_ready", bus.cfg_ready_o, 0);
    cyc();
    bus.rsp_valid_i = 1'b1;
    #1;
    chk("drain_d3_ready", bus.cfg_ready_o, 0);
    cyc();
    chk("drain_d4_ready", bus.cfg_ready_o, 0);
    chk("drain_d4_valid", bus.req_valid_o, 0);
    cyc();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("upd14_ready", bus.cfg_ready_o, 1);
    chk("upd14_seq_old", bus.seq_bits_o, 13);
    chk("upd14_valid_closed", bus.req_valid_o, 0);
    bus.cfg_valid_i = 1'b0;
    bus.req_ready_i = 1'b0;
    cyc();
    chk("upd14_seq", bus.seq_bits_o, 14);
    chk("upd14_busy", bus.busy_o, 0);
    chk("upd14_gate_reopen", bus.req_valid_o, 1);
    bus.req_valid_i = 1'b0;

    // Fill to MaxOutstanding, then simultaneous rsp+req at count 7.
    fill(7);
    bus.req_valid_i = 1'b1;
    bus.req_ready_i = 1'b1;
    #1;
    chk("cnt7_ready", bus.req_ready_o, 1);
    cyc();
    chk("full_ready", bus.req_ready_o, 0);
    chk("full_valid", bus.req_valid_o, 0);
    bus.rsp_valid_i = 1'b1;
    cyc();
    chk("after_rsp_ready", bus.req_ready_o, 1);
    cyc();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("same_cycle_hold_ready", bus.req_ready_o, 1);
    cyc();
    chk("same_cycle_then_full", bus.req_ready_o, 0);
    bus.req_valid_i = 1'b0;
    bus.req_ready_i = 1'b0;
    drain(8);
    drain(1);

    // An extra response at zero must not wrap the counter.
    fill(7);
    bus.req_valid_i = 1'b1;
    bus.req_ready_i = 1'b1;
    #1;
    chk("no_underflow_7", bus.req_ready_o, 1);
    cyc();
    chk("no_underflow_8", bus.req_ready_o, 0);
    bus.req_valid_i = 1'b0;
    bus.req_ready_i = 1'b0;
    drain(8);

    // Reset in DRAIN with two outstanding.
    fill(2);
    bus.cfg_valid_i = 1'b1;
    bus.cfg_seq_bits_i = 5'd15;
    cyc();
    chk("rst_drain_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_drain_no_ready", bus.cfg_ready_o, 0);
    cyc();
    rst = 1'b0;
    bus.cfg_valid_i = 1'b0;
    #1;
    chk("rst_abort_busy", bus.busy_o, 0);
    chk("rst_abort_seq", bus.seq_bits_o, 12);
    chk("rst_abort_ready", bus.cfg_ready_o, 0);
    cyc();
    chk("rst_abort_ready2", bus.cfg_ready_o, 0);
    fill(7);
    bus.req_valid_i = 1'b1;
    bus.req_ready_i = 1'b1;
    #1;
    chk("rst_cnt_7", bus.req_ready_o, 1);
    cyc();
    chk("rst_cnt_8", bus.req_ready_o, 0);
    bus.req_valid_i = 1'b0;
    bus.req_ready_i = 1'b0;
    drain(8);

    // Bypass with seq_bits 0 is legal.
    bus.cfg_valid_i = 1'b1;
    bus.cfg_bypass_i = 1'b1;
    bus.cfg_seq_bits_i = 5'd0;
    #1;
    chk("byp_c0_err", bus.cfg_err_o, 0);
    chk("byp_c0_ready", bus.cfg_ready_o, 0);
    cyc();
    cyc();
    chk("byp_c2_ready", bus.cfg_ready_o, 1);
    chk("byp_c2_err", bus.cfg_err_o, 0);
    bus.cfg_valid_i = 1'b0;
    cyc();
    chk("byp_on", bus.bypass_o, 1);
    chk("byp_busy", bus.busy_o, 0);

    // Lower boundary 5 rejected, 6 accepted; valid dropped during DRAIN.
    bus.cfg_valid_i = 1'b1;
    bus.cfg_bypass_i = 1'b0;
    bus.cfg_seq_bits_i = 5'd5;
    #1;
    chk("min5_err", bus.cfg_err_o, 1);
    bus.cfg_seq_bits_i = 5'd6;
    #1;
    chk("min6_err", bus.cfg_err_o, 0);
    chk("min6_ready", bus.cfg_ready_o, 0);
    cyc();
    chk("min6_busy", bus.busy_o, 1);
    bus.cfg_valid_i = 1'b0;
    cyc();
    chk("min6_ready_upd", bus.cfg_ready_o, 1);
    cyc();
    chk("min6_seq", bus.seq_bits_o, 6);
    chk("min6_bypass_off", bus.bypass_o, 0);
    chk("min6_busy_done", bus.busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
